// File: rtl/regfile_write_arbiter.sv
// Four-requester round-robin write arbiter in front of a 16-entry register file.
// A grant takes one WRITE cycle, so a new grant can be issued at most every other cycle.
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter bit PROTECT_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [3:0]        req,
    input  logic [3:0]        addr0,
    input  logic [3:0]        addr1,
    input  logic [3:0]        addr2,
    input  logic [3:0]        addr3,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    input  logic              stall,
    output logic [3:0]        ack,
    output logic [15:0]       wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [15:0]       wr_count
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]        r_state;
    logic [1:0]        r_ptr;
    logic [3:0]        r_ack;
    logic [15:0]       r_wrEn;
    logic [DATA_W-1:0] r_wrData;
    logic              r_busy;
    logic [15:0]       r_wrCount;

    logic              w_found;
    logic [1:0]        w_winner;
    logic [1:0]        w_idx;
    logic [3:0]        w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_grant;
    logic              w_blockR0;

    // Search starts at the pointer and wraps, so the first set request after ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 2'd0;
        w_idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_addr = addr0;
        w_data = data0;
        case (w_winner)
            2'd0: begin w_addr = addr0; w_data = data0; end
            2'd1: begin w_addr = addr1; w_data = data1; end
            2'd2: begin w_addr = addr2; w_data = data2; end
            default: begin w_addr = addr3; w_data = data3; end
        endcase
    end

    assign w_grant   = (r_state == IDLE) && !stall && w_found;
    assign w_blockR0 = PROTECT_R0 && (w_addr == 4'd0);

    // Write data deliberately holds after the WRITE cycle; only enables and ack drop.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_ack     <= 4'b0000;
            r_wrEn    <= 16'h0000;
            r_wrData  <= '0;
            r_busy    <= 1'b0;
            r_wrCount <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_ack     <= 4'b0001 << w_winner;
                        r_wrEn    <= w_blockR0 ? 16'h0000 : (16'h0001 << w_addr);
                        r_wrData  <= w_data;
                        r_busy    <= 1'b1;
                        r_ptr     <= w_winner + 2'd1;
                        r_wrCount <= r_wrCount + 16'd1;
                        r_state   <= WRITE;
                    end else begin
                        r_ack  <= 4'b0000;
                        r_wrEn <= 16'h0000;
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                    r_ack   <= 4'b0000;
                    r_wrEn  <= 16'h0000;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign wr_en    = r_wrEn;
    assign wr_data  = r_wrData;
    assign busy     = r_busy;
    assign wr_count = r_wrCount;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a vector table for single grants plus
// hand-written sequences for round-robin, stall, reset mid-write, R0 protection and wrap.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        clr;
    logic [3:0]  req;
    logic [3:0]  addr0, addr1, addr2, addr3;
    logic [31:0] data0, data1, data2, data3;
    logic        stall;

    logic [3:0]  ack,     ackP;
    logic [15:0] wrEn,    wrEnP;
    logic [31:0] wrData,  wrDataP;
    logic        busy,    busyP;
    logic [15:0] wrCount, wrCountP;

    int testsRun;
    int testsFailed;

    typedef struct {
        string       name;
        logic [3:0]  req;
        logic        stall;
        logic [3:0]  expAck;
        logic [15:0] expWrEn;
        logic [31:0] expData;
        logic        expBusy;
        logic [15:0] expCount;
    } vector_t;

    vector_t vecs[6];

    regfile_write_arbiter #(.DATA_W(32), .PROTECT_R0(1'b0)) dut (
        .clk(clk), .clr(clr), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .stall(stall), .ack(ack), .wr_en(wrEn), .wr_data(wrData),
        .busy(busy), .wr_count(wrCount)
    );

    regfile_write_arbiter #(.DATA_W(32), .PROTECT_R0(1'b1)) dutP (
        .clk(clk), .clr(clr), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .stall(stall), .ack(ackP), .wr_en(wrEnP), .wr_data(wrDataP),
        .busy(busyP), .wr_count(wrCountP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqV, input logic stallV);
        req   = reqV;
        stall = stallV;
    endtask

    task automatic doReset();
        clr = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rrExp[10];

        testsRun    = 0;
        testsFailed = 0;
        clr   = 1'b1;
        req   = 4'b0000;
        stall = 1'b0;
        addr0 = 4'd5;  data0 = 32'hA5A5A5A5;
        addr1 = 4'd3;  data1 = 32'h11111111;
        addr2 = 4'd9;  data2 = 32'hDEADBEEF;
        addr3 = 4'd15; data3 = 32'hCAFEF00D;

        vecs[0] = '{"single_req2",  4'b0100, 1'b0, 4'b0100, 16'h0200, 32'hDEADBEEF, 1'b1, 16'd1};
        vecs[1] = '{"req1_over_3",  4'b1010, 1'b0, 4'b0010, 16'h0008, 32'h11111111, 1'b1, 16'd1};
        vecs[2] = '{"req3_addr15",  4'b1000, 1'b0, 4'b1000, 16'h8000, 32'hCAFEF00D, 1'b1, 16'd1};
        vecs[3] = '{"req0_over_1",  4'b0011, 1'b0, 4'b0001, 16'h0020, 32'hA5A5A5A5, 1'b1, 16'd1};
        vecs[4] = '{"stalled",      4'b0001, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 1'b0, 16'd0};
        vecs[5] = '{"no_req",       4'b0000, 1'b0, 4'b0000, 16'h0000, 32'h00000000, 1'b0, 16'd0};

        // Reset state
        @(negedge clk);
        clr = 1'b0;
        checkOutput("reset_ack",     32'(ack),     32'h0);
        checkOutput("reset_wr_en",   32'(wrEn),    32'h0);
        checkOutput("reset_wr_data", wrData,       32'h0);
        checkOutput("reset_busy",    32'(busy),    32'h0);
        checkOutput("reset_count",   32'(wrCount), 32'h0);

        // Table-driven single grants from a fresh reset (ptr=0)
        for (int i = 0; i < 6; i++) begin
            doReset();
            applyStimulus(vecs[i].req, vecs[i].stall);
            nextCycle();
            checkOutput({vecs[i].name, "_ack"},   32'(ack),     32'(vecs[i].expAck));
            checkOutput({vecs[i].name, "_wr_en"}, 32'(wrEn),    32'(vecs[i].expWrEn));
            checkOutput({vecs[i].name, "_data"},  wrData,       vecs[i].expData);
            checkOutput({vecs[i].name, "_busy"},  32'(busy),    32'(vecs[i].expBusy));
            checkOutput({vecs[i].name, "_count"}, 32'(wrCount), 32'(vecs[i].expCount));
            applyStimulus(4'b0000, 1'b0);
            nextCycle();
            checkOutput({vecs[i].name, "_ack_drop"},   32'(ack),  32'h0);
            checkOutput({vecs[i].name, "_wr_en_drop"}, 32'(wrEn), 32'h0);
            checkOutput({vecs[i].name, "_busy_drop"},  32'(busy), 32'h0);
            checkOutput({vecs[i].name, "_data_hold"},  wrData,    vecs[i].expData);
        end

        // Round-robin with all requests held: one grant every other cycle
        rrExp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        doReset();
        applyStimulus(4'b1111, 1'b0);
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            checkOutput($sformatf("rr_ack_%0d", i),  32'(ack),  32'(rrExp[i]));
            checkOutput($sformatf("rr_busy_%0d", i), 32'(busy), 32'(rrExp[i] != 4'b0000));
        end
        checkOutput("rr_count", 32'(wrCount), 32'd5);

        // Stall holds off the grant until released
        doReset();
        applyStimulus(4'b0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            checkOutput($sformatf("stall_ack_%0d", i),   32'(ack),  32'h0);
            checkOutput($sformatf("stall_wr_en_%0d", i), 32'(wrEn), 32'h0);
        end
        applyStimulus(4'b0001, 1'b0);
        nextCycle();
        checkOutput("unstall_ack",   32'(ack),  32'h1);
        checkOutput("unstall_wr_en", 32'(wrEn), 32'h0020);
        applyStimulus(4'b0000, 1'b1);
        nextCycle();
        checkOutput("stall_in_write_ack", 32'(ack),     32'h0);
        checkOutput("stall_in_write_cnt", 32'(wrCount), 32'd1);

        // Reset in the WRITE cycle drops the write and resets the pointer
        doReset();
        applyStimulus(4'b1111, 1'b0);
        nextCycle();
        checkOutput("midwr_first_ack", 32'(ack), 32'h1);
        clr = 1'b1;
        nextCycle();
        checkOutput("midwr_ack",   32'(ack),     32'h0);
        checkOutput("midwr_wr_en", 32'(wrEn),    32'h0);
        checkOutput("midwr_count", 32'(wrCount), 32'h0);
        checkOutput("midwr_busy",  32'(busy),    32'h0);
        clr = 1'b0;
        nextCycle();
        checkOutput("midwr_ptr_zero_ack", 32'(ack), 32'h1);

        // R0 protection: same request on both instances, only the protected one suppresses wr_en
        doReset();
        addr0 = 4'd0;
        applyStimulus(4'b0001, 1'b0);
        nextCycle();
        checkOutput("r0_plain_wr_en", 32'(wrEn),     32'h0001);
        checkOutput("r0_prot_ack",    32'(ackP),     32'h1);
        checkOutput("r0_prot_wr_en",  32'(wrEnP),    32'h0);
        checkOutput("r0_prot_count",  32'(wrCountP), 32'd1);
        checkOutput("r0_prot_busy",   32'(busyP),    32'h1);
        applyStimulus(4'b0000, 1'b0);
        addr0 = 4'd5;
        nextCycle();

        // Counter wrap: preload near the top instead of running 65535 grants
        doReset();
        dut.r_wrCount = 16'hFFFE;
        applyStimulus(4'b0001, 1'b0);
        nextCycle();
        checkOutput("wrap_ffff", 32'(wrCount), 32'h0000FFFF);
        nextCycle();
        nextCycle();
        checkOutput("wrap_ack",  32'(ack),     32'h1);
        checkOutput("wrap_zero", 32'(wrCount), 32'h00000000);
        applyStimulus(4'b0000, 1'b0);
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
